// File: rtl/cia_serial_peer.sv
// Far-end serial partner for a 6526 CIA SP/CNT pair: receives bytes clocked by the CIA
// and transmits bytes by driving CNT itself, MSB first, behind byte-wide valid/ready ports.
module cia_serial_peer #(
    parameter int HALF_PERIOD = 8,
    parameter int RX_TIMEOUT  = 4096
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_overrun,
    output logic       rx_frame_err,
    input  logic       cnt_in,
    input  logic       sp_in,
    output logic       cnt_out,
    output logic       cnt_oe,
    output logic       sp_out,
    output logic       busy
);

    localparam int HP_W = $clog2(HALF_PERIOD);
    localparam int TO_W = $clog2(RX_TIMEOUT + 1);
    localparam logic [HP_W-1:0] HP_LAST = HP_W'(HALF_PERIOD - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(RX_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOW   = 2'd1,
        ST_HIGH  = 2'd2,
        ST_GUARD = 2'd3
    } tx_state_e;

    logic            cnt_s1_q, cnt_s2_q, cnt_s3_q, sp_s1_q, sp_s2_q;
    tx_state_e       state_q, state_d;
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic [2:0]      bit_q, bit_d;
    logic [HP_W-1:0] ph_q, ph_d;
    logic            cnt_oe_q, cnt_oe_d, cnt_out_q, cnt_out_d, sp_out_q, sp_out_d;
    logic [7:0]      shift_q, shift_d, rx_data_q, rx_data_d;
    logic [2:0]      rx_cnt_q, rx_cnt_d;
    logic [TO_W-1:0] tmo_q, tmo_d;
    logic            rx_valid_q, rx_valid_d, ovr_q, ovr_d, ferr_q, ferr_d;

    logic       rise_s, tx_ready_s, accept_s, rx_en_s, rx_take_s, ph_last_s;
    logic [7:0] shifted_s;

    assign rise_s     = cnt_s2_q & ~cnt_s3_q;
    assign tx_ready_s = (state_q == ST_IDLE) & (rx_cnt_q == 3'd0);
    assign accept_s   = tx_valid & tx_ready_s;
    // Our own CNT edges, and any edge in the accept cycle, must not reach the receiver.
    assign rx_en_s    = ~cnt_oe_q & ~accept_s;
    assign rx_take_s  = rx_valid_q & rx_ready;
    assign ph_last_s  = (ph_q == HP_LAST);
    assign shifted_s  = {shift_q[6:0], sp_s2_q};

    // Pin synchronisers; reset high so release never looks like a CNT rise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_s1_q <= 1'b1;
            cnt_s2_q <= 1'b1;
            cnt_s3_q <= 1'b1;
            sp_s1_q  <= 1'b1;
            sp_s2_q  <= 1'b1;
        end else begin
            cnt_s1_q <= cnt_in;
            cnt_s2_q <= cnt_s1_q;
            cnt_s3_q <= cnt_s2_q;
            sp_s1_q  <= sp_in;
            sp_s2_q  <= sp_s1_q;
        end
    end

    // Transmit FSM next-state and registered pin drive values.
    always_comb begin
        state_d   = state_q;
        tx_byte_d = tx_byte_q;
        bit_d     = bit_q;
        ph_d      = ph_q;
        cnt_oe_d  = cnt_oe_q;
        cnt_out_d = cnt_out_q;
        sp_out_d  = sp_out_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    tx_byte_d = tx_data;
                    bit_d     = 3'd7;
                    ph_d      = {HP_W{1'b0}};
                    cnt_oe_d  = 1'b1;
                    cnt_out_d = 1'b0;
                    sp_out_d  = tx_data[7];
                    state_d   = ST_LOW;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_LOW: begin
                if (ph_last_s) begin
                    ph_d      = {HP_W{1'b0}};
                    cnt_out_d = 1'b1;
                    state_d   = ST_HIGH;
                end else begin
                    ph_d      = ph_q + HP_W'(1);
                end
            end
            ST_HIGH: begin
                if (ph_last_s) begin
                    ph_d = {HP_W{1'b0}};
                    if (bit_q == 3'd0) begin
                        sp_out_d = 1'b1;
                        state_d  = ST_GUARD;
                    end else begin
                        bit_d     = bit_q - 3'd1;
                        cnt_out_d = 1'b0;
                        sp_out_d  = tx_byte_q[bit_q - 3'd1];
                        state_d   = ST_LOW;
                    end
                end else begin
                    ph_d = ph_q + HP_W'(1);
                end
            end
            ST_GUARD: begin
                if (ph_last_s) begin
                    ph_d     = {HP_W{1'b0}};
                    cnt_oe_d = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    ph_d     = ph_q + HP_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                ph_d      = {HP_W{1'b0}};
                cnt_oe_d  = 1'b0;
                cnt_out_d = 1'b1;
                sp_out_d  = 1'b1;
            end
        endcase
    end

    // Receive shifter, byte hand-off, overrun and inter-bit timeout.
    always_comb begin
        shift_d    = shift_q;
        rx_cnt_d   = rx_cnt_q;
        tmo_d      = tmo_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q & ~rx_take_s;
        ovr_d      = 1'b0;
        ferr_d     = 1'b0;
        if (rx_en_s && rise_s) begin
            shift_d  = shifted_s;
            rx_cnt_d = rx_cnt_q + 3'd1;
            tmo_d    = {TO_W{1'b0}};
            if (rx_cnt_q == 3'd7) begin
                // A consumer taking the old byte this cycle frees the slot for the new one.
                if (!rx_valid_q || rx_take_s) begin
                    rx_data_d  = shifted_s;
                    rx_valid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end else begin
                ovr_d = 1'b0;
            end
        end else if (rx_en_s && (rx_cnt_q != 3'd0)) begin
            if (tmo_q == TO_LAST) begin
                shift_d  = 8'h00;
                rx_cnt_d = 3'd0;
                tmo_d    = {TO_W{1'b0}};
                ferr_d   = 1'b1;
            end else begin
                tmo_d    = tmo_q + TO_W'(1);
            end
        end else begin
            tmo_d = tmo_q;
        end
    end

    // State registers for both directions.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            tx_byte_q  <= 8'h00;
            bit_q      <= 3'd0;
            ph_q       <= {HP_W{1'b0}};
            cnt_oe_q   <= 1'b0;
            cnt_out_q  <= 1'b1;
            sp_out_q   <= 1'b1;
            shift_q    <= 8'h00;
            rx_cnt_q   <= 3'd0;
            tmo_q      <= {TO_W{1'b0}};
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_byte_q  <= tx_byte_d;
            bit_q      <= bit_d;
            ph_q       <= ph_d;
            cnt_oe_q   <= cnt_oe_d;
            cnt_out_q  <= cnt_out_d;
            sp_out_q   <= sp_out_d;
            shift_q    <= shift_d;
            rx_cnt_q   <= rx_cnt_d;
            tmo_q      <= tmo_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
        end
    end

    assign tx_ready     = tx_ready_s;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_overrun   = ovr_q;
    assign rx_frame_err = ferr_q;
    assign cnt_out      = cnt_out_q;
    assign cnt_oe       = cnt_oe_q;
    assign sp_out       = sp_out_q;
    assign busy         = (state_q != ST_IDLE) | (rx_cnt_q != 3'd0) | rx_valid_q;

endmodule

// File: tb/tb_cia_serial_peer.sv
// Bench for cia_serial_peer: a CIA-style bit driver plus a byte-level model of the
// receive slot (held byte, overrun and frame-error counts) and MSB-first tx expectations.
module tb_cia_serial_peer;

    localparam int HP  = 8;
    localparam int TMO = 256;
    localparam int CIA_PHASE = 20;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready, rx_overrun, rx_frame_err;
    logic       cnt_in, sp_in, cnt_out, cnt_oe, sp_out, busy;
    logic       cia_cnt, cia_sp;

    int n_tests = 0;
    int n_fail  = 0;
    int ovr_seen  = 0;
    int ferr_seen = 0;

    // byte-level model of the receive holding slot
    bit       m_valid = 1'b0;
    bit [7:0] m_data  = 8'h00;
    int       m_ovr   = 0;
    int       m_ferr  = 0;

    cia_serial_peer #(.HALF_PERIOD(HP), .RX_TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err),
        .cnt_in(cnt_in), .sp_in(sp_in),
        .cnt_out(cnt_out), .cnt_oe(cnt_oe), .sp_out(sp_out), .busy(busy)
    );

    assign cnt_in = cnt_oe ? cnt_out : cia_cnt;
    assign sp_in  = cia_sp;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_overrun === 1'b1)   ovr_seen++;
        if (rx_frame_err === 1'b1) ferr_seen++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_byte(input bit [7:0] b);
        if (m_valid) m_ovr++;
        else begin
            m_valid = 1'b1;
            m_data  = b;
        end
    endfunction

    // Low phase with new SP, then rise; returns on the negedge that drove the rise.
    task automatic cia_bit(input logic b);
        cia_cnt = 1'b0;
        cia_sp  = b;
        repeat (CIA_PHASE) @(negedge clk);
        cia_cnt = 1'b1;
    endtask

    task automatic cia_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            cia_bit(v[i]);
            repeat (CIA_PHASE) @(negedge clk);
        end
        model_byte(v);
    endtask

    task automatic consume(input string tag);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        m_valid  = 1'b0;
        n_tests++;
        if (rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_consume: rx_valid=%b expected 0", tag, rx_valid);
        end
    endtask

    task automatic check_slot(input string tag);
        n_tests++;
        if (rx_valid !== m_valid || (m_valid && rx_data !== m_data)) begin
            n_fail++;
            $display("FAIL %s_slot: rx_valid=%b rx_data=%02h expected %b/%02h",
                     tag, rx_valid, rx_data, m_valid, m_data);
        end
    endtask

    // Called on the first negedge with cnt_oe=1; follows one byte to its end.
    task automatic watch_tx(input logic [7:0] v, input string tag);
        int oe_cycles, nb;
        logic prev;
        logic [7:0] got;
        bit done;
        oe_cycles = 0; nb = 0; prev = 1'b1; got = 8'h00; done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            if (c > 0) @(negedge clk);
            if (cnt_oe === 1'b1) begin
                oe_cycles++;
                if (prev === 1'b0 && cnt_out === 1'b1) begin
                    if (nb < 8) got[7-nb] = sp_out;
                    nb++;
                end
                prev = cnt_out;
            end else begin
                done = 1'b1;
            end
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_end: cnt_oe still high after 400 clk", tag);
        end
        n_tests++;
        if (oe_cycles != 17 * HP) begin
            n_fail++;
            $display("FAIL %s_oe_len: %0d clk expected %0d", tag, oe_cycles, 17 * HP);
        end
        n_tests++;
        if (nb != 8 || got !== v) begin
            n_fail++;
            $display("FAIL %s_bits: %0d rises, sampled %02h expected 8 rises %02h", tag, nb, got, v);
        end
        n_tests++;
        if (tx_ready !== 1'b1 || cnt_out !== 1'b1 || sp_out !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_idle: tx_ready=%b cnt_out=%b sp_out=%b expected 1/1/1",
                     tag, tx_ready, cnt_out, sp_out);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0;
        cia_cnt = 1'b1; cia_sp = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({cnt_out, cnt_oe, sp_out, tx_ready, rx_valid, rx_overrun, rx_frame_err, busy}
                !== 8'b1011_0000 || rx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset: cnt_out/oe/sp/tx_ready/rx_valid/ovr/ferr/busy=%b rx_data=%02h expected 10110000/00",
                     {cnt_out, cnt_oe, sp_out, tx_ready, rx_valid, rx_overrun, rx_frame_err, busy}, rx_data);
        end
    endtask

    task automatic test_tx(input logic [7:0] v);
        tx_data  = v;
        tx_valid = 1'b1;
        n_tests++;
        if (tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL tx_ready_pre: tx_ready=%b expected 1", tx_ready);
        end
        @(negedge clk);
        tx_valid = 1'b0;
        watch_tx(v, "tx");
    endtask

    task automatic test_rx(input logic [7:0] v);
        for (int i = 7; i >= 1; i--) begin
            cia_bit(v[i]);
            repeat (CIA_PHASE) @(negedge clk);
        end
        cia_bit(v[0]);
        repeat (2) @(negedge clk);
        n_tests++;
        if (rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rx_early: rx_valid=%b at 2 clk expected 0", rx_valid);
        end
        @(negedge clk);
        model_byte(v);
        n_tests++;
        if (rx_valid !== 1'b1 || rx_data !== v) begin
            n_fail++;
            $display("FAIL rx_latency: rx_valid=%b rx_data=%02h at 3 clk expected 1/%02h",
                     rx_valid, rx_data, v);
        end
        repeat (CIA_PHASE - 3) @(negedge clk);
        check_slot("rx_hold");
        consume("rx");
    endtask

    task automatic test_overrun(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        int ovr0;
        ovr0 = ovr_seen;
        m_ovr = 0;
        cia_byte(a);
        cia_byte(b);
        check_slot("ovr");
        n_tests++;
        if (ovr_seen - ovr0 != m_ovr) begin
            n_fail++;
            $display("FAIL ovr_pulses: %0d seen expected %0d", ovr_seen - ovr0, m_ovr);
        end
        consume("ovr");
        // New byte completes in the same cycle the consumer takes the old one.
        cia_byte(a);
        ovr0 = ovr_seen;
        for (int i = 7; i >= 1; i--) begin
            cia_bit(c[i]);
            repeat (CIA_PHASE) @(negedge clk);
        end
        cia_bit(c[0]);
        repeat (2) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        m_data = c;
        repeat (CIA_PHASE - 3) @(negedge clk);
        check_slot("same_cycle");
        n_tests++;
        if (ovr_seen != ovr0) begin
            n_fail++;
            $display("FAIL same_cycle_ovr: %0d pulses expected 0", ovr_seen - ovr0);
        end
        consume("same_cycle");
    endtask

    task automatic test_timeout(input logic [7:0] v);
        int ferr0;
        ferr0 = ferr_seen;
        for (int i = 0; i < 3; i++) begin
            cia_bit(i[0]);
            repeat (CIA_PHASE) @(negedge clk);
        end
        n_tests++;
        if (busy !== 1'b1 || tx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_partial: busy=%b tx_ready=%b expected 1/0", busy, tx_ready);
        end
        repeat (300) @(negedge clk);
        m_ferr = 1;
        n_tests++;
        if (ferr_seen - ferr0 != m_ferr || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_frame_err: %0d pulses busy=%b expected %0d/0",
                     ferr_seen - ferr0, busy, m_ferr);
        end
        cia_byte(v);
        check_slot("tmo_next");
        consume("tmo");
    endtask

    task automatic test_reset_mid_tx;
        int rises, ovr0, ferr0;
        logic prev;
        ovr0 = ovr_seen; ferr0 = ferr_seen;
        tx_data = 8'hFF; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        rises = 0; prev = cnt_out;
        for (int c = 0; c < 200 && rises < 3; c++) begin
            @(negedge clk);
            if (prev === 1'b0 && cnt_out === 1'b1) rises++;
            prev = cnt_out;
        end
        repeat (HP + 1) @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (rises != 3 || cnt_oe !== 1'b0 || cnt_out !== 1'b1 || sp_out !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_tx: rises=%0d cnt_oe=%b cnt_out=%b sp_out=%b expected 3/0/1/1",
                     rises, cnt_oe, cnt_out, sp_out);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (tx_ready !== 1'b1 || busy !== 1'b0 || ovr_seen != ovr0 || ferr_seen != ferr0) begin
            n_fail++;
            $display("FAIL reset_release: tx_ready=%b busy=%b pulses=%0d expected 1/0/0",
                     tx_ready, busy, (ovr_seen - ovr0) + (ferr_seen - ferr0));
        end
    endtask

    task automatic test_contention(input logic [7:0] v, input logic [7:0] w);
        bit started;
        cia_bit(v[7]); repeat (CIA_PHASE) @(negedge clk);
        cia_bit(v[6]); repeat (CIA_PHASE) @(negedge clk);
        tx_data = w; tx_valid = 1'b1;
        for (int i = 5; i >= 1; i--) begin
            n_tests++;
            if (tx_ready !== 1'b0 || cnt_oe !== 1'b0) begin
                n_fail++;
                $display("FAIL cont_block_%0d: tx_ready=%b cnt_oe=%b expected 0/0", i, tx_ready, cnt_oe);
            end
            cia_bit(v[i]); repeat (CIA_PHASE) @(negedge clk);
        end
        cia_bit(v[0]);
        repeat (2) @(negedge clk);
        n_tests++;
        if (cnt_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL cont_early: cnt_oe=%b before byte completion expected 0", cnt_oe);
        end
        model_byte(v);
        started = 1'b0;
        for (int c = 0; c < 10 && !started; c++) begin
            @(negedge clk);
            if (cnt_oe === 1'b1) started = 1'b1;
        end
        tx_valid = 1'b0;
        n_tests++;
        if (!started) begin
            n_fail++;
            $display("FAIL cont_start: cnt_oe=%b 12 clk after rx byte expected 1", cnt_oe);
        end else begin
            watch_tx(w, "cont_tx");
        end
        check_slot("cont_rx");
        consume("cont");
    endtask

    initial begin
        test_reset();
        test_tx(8'hA5);
        for (int i = 0; i < 2; i++) test_tx(8'($urandom));
        test_rx(8'h3C);
        for (int i = 0; i < 2; i++) test_rx(8'($urandom));
        test_overrun(8'h11, 8'h22, 8'($urandom));
        test_timeout(8'h7E);
        test_reset_mid_tx();
        test_contention(8'($urandom), 8'($urandom));
        test_tx(8'h00);
        test_tx(8'hFF);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
